// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Parametrised Y86-64 pipeline stage register. Captures the
//            instruction fields (stat, icode, ifun, valA/valB/valC, dstE,
//            dstM) on each rising clock edge, with synchronous reset,
//            stall (hold) and bubble (nop injection) controls and a valid
//            bit. One instance sits at each D/E/M/W boundary.
//
//            Edge priority: rst > bubble > stall > load.
//
// Optional : PIPE_STAGE_REG_PERF_CNT_EN
//            defined   -> stall_cnt, bubble_cnt (saturating) and the sticky
//                         ctl_conflict flag are implemented.
//            undefined -> those outputs are tied to 0. The stall/bubble
//                         priority is the same in both builds.
//
// Ports    : clk, rst             clock / synchronous active-high reset
//            stall, bubble        hazard-unit controls, sampled with data
//            in_*                 incoming instruction fields
//            out_*                registered instruction fields
//            out_valid            1 = register holds a real instruction
//            ctl_conflict         sticky: stall and bubble seen together
//            stall_cnt            effective stall cycles (saturating)
//            bubble_cnt           bubble cycles (saturating)
//
// Revision : 1.0  initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int              WORD_W      = 64,
    parameter int              REG_W       = 4,
    parameter int              STAT_W      = 3,
    parameter logic [3:0]      NOP_ICODE   = 4'h1,
    parameter logic [REG_W-1:0] NONE_REG   = 4'hF,
    parameter logic [STAT_W-1:0] BUBBLE_STAT = 3'h0,
    parameter int              CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              bubble,
    input  logic [STAT_W-1:0] in_stat,
    input  logic [3:0]        in_icode,
    input  logic [3:0]        in_ifun,
    input  logic [WORD_W-1:0] in_valA,
    input  logic [WORD_W-1:0] in_valB,
    input  logic [WORD_W-1:0] in_valC,
    input  logic [REG_W-1:0]  in_dstE,
    input  logic [REG_W-1:0]  in_dstM,
    output logic [STAT_W-1:0] out_stat,
    output logic [3:0]        out_icode,
    output logic [3:0]        out_ifun,
    output logic [WORD_W-1:0] out_valA,
    output logic [WORD_W-1:0] out_valB,
    output logic [WORD_W-1:0] out_valC,
    output logic [REG_W-1:0]  out_dstE,
    output logic [REG_W-1:0]  out_dstM,
    output logic              out_valid,
    output logic              ctl_conflict,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // ------------------------------------------------------------------------
    // Control decode. A bubble overrides a stall, so a stall is only
    // "effective" (holds state, counts) when no bubble accompanies it.
    // ------------------------------------------------------------------------
    logic w_eff_stall;
    logic w_conflict_now;

    assign w_eff_stall    = stall & ~bubble;
    assign w_conflict_now = stall & bubble;

    // ------------------------------------------------------------------------
    // Instruction field registers
    // ------------------------------------------------------------------------
    logic [STAT_W-1:0] r_stat;
    logic [3:0]        r_icode;
    logic [3:0]        r_ifun;
    logic [WORD_W-1:0] r_valA;
    logic [WORD_W-1:0] r_valB;
    logic [WORD_W-1:0] r_valC;
    logic [REG_W-1:0]  r_dstE;
    logic [REG_W-1:0]  r_dstM;
    logic              r_valid;

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            // Reset and bubble both leave a nop in the register.
            r_stat  <= BUBBLE_STAT;
            r_icode <= NOP_ICODE;
            r_ifun  <= 4'h0;
            r_valA  <= '0;
            r_valB  <= '0;
            r_valC  <= '0;
            r_dstE  <= NONE_REG;
            r_dstM  <= NONE_REG;
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_stat  <= in_stat;
            r_icode <= in_icode;
            r_ifun  <= in_ifun;
            r_valA  <= in_valA;
            r_valB  <= in_valB;
            r_valC  <= in_valC;
            r_dstE  <= in_dstE;
            r_dstM  <= in_dstM;
            r_valid <= 1'b1;
        end
        // stall without bubble: everything holds
    end

    assign out_stat  = r_stat;
    assign out_icode = r_icode;
    assign out_ifun  = r_ifun;
    assign out_valA  = r_valA;
    assign out_valB  = r_valB;
    assign out_valC  = r_valC;
    assign out_dstE  = r_dstE;
    assign out_dstM  = r_dstM;
    assign out_valid = r_valid;

    // ------------------------------------------------------------------------
    // Hazard diagnostics
    // ------------------------------------------------------------------------
`ifdef PIPE_STAGE_REG_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic             r_conflict;
    logic             w_stall_sat;
    logic             w_bubble_sat;

    // All-ones means the counter has reached its ceiling.
    assign w_stall_sat  = &r_stall_cnt;
    assign w_bubble_sat = &r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_conflict   <= 1'b0;
        end else begin
            if (w_eff_stall && !w_stall_sat) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (bubble && !w_bubble_sat) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
            // Sticky until the next reset.
            if (w_conflict_now) begin
                r_conflict <= 1'b1;
            end
        end
    end

    assign stall_cnt    = r_stall_cnt;
    assign bubble_cnt   = r_bubble_cnt;
    assign ctl_conflict = r_conflict;
`else
    // Diagnostics compiled out; decode terms exist only for the counters.
    logic w_unused_diag;
    assign w_unused_diag = w_eff_stall ^ w_conflict_now;

    assign stall_cnt    = '0;
    assign bubble_cnt   = '0;
    assign ctl_conflict = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised Y86-64 pipeline stage register, the generalised successor of the fixed-width Execute-stage register. It captures the instruction fields (status, icode, ifun, three data words, two destination register IDs) on every clock edge. It supports synchronous reset, stall (hold) and bubble (inject nop) with a defined priority, and tracks a valid bit. Hazard-diagnostic counters can be compiled in. One instance sits at each of the D/E/M/W boundaries, between the hazard control unit and the next stage's datapath.

## Interface
Parameters:
- WORD_W, 64, width of valA/valB/valC
- REG_W, 4, width of register IDs
- STAT_W, 3, width of status field
- NOP_ICODE, 4'h1, icode loaded on bubble/reset
- NONE_REG, 4'hF, register ID loaded into dstE/dstM on bubble/reset (RNONE)
- BUBBLE_STAT, 3'h0, status loaded on bubble/reset
- CNT_W, 16, width of diagnostic counters

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous active-high reset
- stall  in  1  hold current contents
- bubble  in  1  load nop instead of inputs
- in_stat  in  STAT_W  incoming status
- in_icode, in_ifun  in  4 each  incoming instruction code/function
- in_valA, in_valB, in_valC  in  WORD_W each  incoming data words
- in_dstE, in_dstM  in  REG_W each  incoming destination IDs
- out_stat, out_icode, out_ifun, out_valA, out_valB, out_valC, out_dstE, out_dstM  out  matching widths  registered fields
- out_valid  out  1  1 = register holds a real instruction
- ctl_conflict  out  1  sticky: stall and bubble were seen asserted together
- stall_cnt  out  CNT_W  effective stall cycles (saturating)
- bubble_cnt  out  CNT_W  bubble cycles (saturating)

## Operation
- Per-edge priority: rst > bubble > stall > load.
- rst: out_stat=BUBBLE_STAT, out_icode=NOP_ICODE, out_ifun=0, out_valA/B/C=0, out_dstE/M=NONE_REG, out_valid=0, ctl_conflict=0, stall_cnt=0, bubble_cnt=0.
- bubble (rst=0): all fields take their reset values; out_valid=0; bubble_cnt increments.
- stall (rst=0, bubble=0): every field and out_valid hold; stall_cnt increments.
- load (rst=0, bubble=0, stall=0): every out_* field takes the matching in_*; out_valid=1.
- stall and bubble both high: bubble wins (nop inserted). ctl_conflict is set and holds until rst. The cycle counts toward bubble_cnt only.
- Counters saturate at 2^CNT_W−1 and do not wrap.
- A rst during a stall sequence clears state immediately. The next edge with stall=1 holds the reset nop with out_valid=0.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- No combinational path from any input to any output; all outputs are flops.
- stall/bubble are sampled at the same edge as the data; the hazard unit drives them combinationally in the preceding cycle.
- ctl_conflict rises on the edge following the coincident assertion.
- Counter values reflect all edges up to and including the last one.

## Configuration
- PIPE_STAGE_REG_PERF_CNT_EN defined: stall_cnt, bubble_cnt and ctl_conflict are implemented as above.
- Not defined: counters and conflict flops are omitted. stall_cnt, bubble_cnt and ctl_conflict are tied to 0, and stall/bubble priority is unchanged.

## Test plan
- Reset then load: rst=1 for one edge → outputs nop/NONE_REG/0, out_valid=0. Then in_icode=4'h6, in_ifun=1, valA=5, valB=7, valC=0, dstE=3 → after next edge out_icode=6, out_dstE=3, out_valid=1.
- Stall hold: load icode=4'h3, valC=0x100, then stall=1 for 3 edges while inputs change → outputs unchanged for all 3 edges, stall_cnt=3.
- Bubble: with valid contents, bubble=1 one edge → out_icode=1, out_dstE=out_dstM=4'hF, out_valA=0, out_valid=0, bubble_cnt=1.
- Conflict: stall=1 and bubble=1 same edge → nop loaded, ctl_conflict=1, bubble_cnt+1, stall_cnt unchanged. ctl_conflict stays 1 across 10 normal loads and clears only on rst.
- Saturation with CNT_W=2: stall held for 5 edges → stall_cnt reads 1,2,3,3,3.
- Reset mid-stall: stall=1 and rst=1 on the same edge → reset values. Then stall=1 for 2 edges → out_valid stays 0 and out_icode stays 1.
